// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, command encodings, FSM/error types and the
// operand-requirement lookup for the ALU operand collector.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 8;
    localparam int ALU_CMD_WIDTH  = 4;

    // Arithmetic-mode commands (MODE=1)
    typedef enum logic [3:0] {
        A_ADD = 4'd0, A_SUB = 4'd1, A_ADD_CIN = 4'd2, A_SUB_CIN = 4'd3,
        A_INC_A = 4'd4, A_DEC_A = 4'd5, A_INC_B = 4'd6, A_DEC_B = 4'd7,
        A_CMP = 4'd8, A_MUL_INC = 4'd9, A_MUL_SHL = 4'd10
    } arith_cmd_t;

    // Logical-mode commands (MODE=0)
    typedef enum logic [3:0] {
        L_AND = 4'd0, L_NAND = 4'd1, L_OR = 4'd2, L_NOR = 4'd3,
        L_XOR = 4'd4, L_XNOR = 4'd5, L_NOT_A = 4'd6, L_NOT_B = 4'd7,
        L_SHR1_A = 4'd8, L_SHL1_A = 4'd9, L_SHR1_B = 4'd10, L_SHL1_B = 4'd11,
        L_ROL = 4'd12, L_ROR = 4'd13
    } logic_cmd_t;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00, ERR_TIMEOUT = 2'b01, ERR_BADREQ = 2'b10, ERR_CMDCHG = 2'b11
    } err_t;

    // Operand mask required by a command: bit0=OPA, bit1=OPB; 00 = illegal.
    function automatic logic [1:0] op_req(input logic mode, input int unsigned cmd);
        logic [1:0] r;
        r = 2'b00;
        if (mode) begin
            case (cmd)
                0, 1, 2, 3, 8, 9, 10: r = 2'b11;
                4, 5:                 r = 2'b01;
                6, 7:                 r = 2'b10;
                default:              r = 2'b00;
            endcase
        end else begin
            case (cmd)
                0, 1, 2, 3, 4, 5, 12, 13: r = 2'b11;
                6, 8, 9:                  r = 2'b01;
                7, 10, 11:                r = 2'b10;
                default:                  r = 2'b00;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_op_collector_if.sv
// alu_op_collector_if: ALU pin-side stimulus signals plus the assembled-op
// outputs. master = stimulus driver, slave = collector.
interface alu_op_collector_if
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int CMD_WIDTH  = ALU_CMD_WIDTH
);
    logic                  CE;
    logic                  MODE;
    logic [CMD_WIDTH-1:0]  CMD;
    logic [1:0]            INP_VALID;
    logic [DATA_WIDTH-1:0] OPA;
    logic [DATA_WIDTH-1:0] OPB;
    logic                  CIN;

    logic                  op_valid;
    logic                  op_mode;
    logic [CMD_WIDTH-1:0]  op_cmd;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  op_cin;
    logic                  op_err;
    logic [1:0]            err_code;
    logic                  busy;

    modport master (
        output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        input  op_valid, op_mode, op_cmd, op_a, op_b, op_cin, op_err, err_code, busy
    );

    modport slave (
        input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        output op_valid, op_mode, op_cmd, op_a, op_b, op_cin, op_err, err_code, busy
    );
endinterface

// File: rtl/alu_wait_timer.sv
// alu_wait_timer: CE-gated wait counter; tc_o flags the last window cycle
// (count == TIMEOUT-1).
module alu_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic ce_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise step only on enabled increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)             cnt_d = '0;
        else if (ce_i && inc_i) cnt_d = cnt_q + 1'b1;
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/alu_op_collector.sv
// alu_op_collector: assembles complete ALU operations from pin stimulus,
// allowing the second operand of two-operand commands to arrive later
// within a TIMEOUT-cycle window.
// Optional: define ALU_CMD_LOCK_CHECK_EN to abort a pending request whose
// MODE/CMD changes while waiting (err_code 11).
module alu_op_collector
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int CMD_WIDTH  = ALU_CMD_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_op_collector_if.slave  bus
);
    state_t                state_q, state_d;
    logic [1:0]            req;
    logic [1:0]            held_q;
    logic                  mode_q, cin_q;
    logic [CMD_WIDTH-1:0]  cmd_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  valid_q, err_q;
    err_t                  ecode_q;

    logic issue, err, ld_full, ld_part, ld_miss, tmr_clr, tmr_inc, tmr_tc, cmd_chg;
    err_t ecode;

    assign req = op_req(bus.MODE, 32'(bus.CMD));

    alu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .ce_i  (bus.CE),
        .clr_i (tmr_clr),
        .inc_i (tmr_inc),
        .tc_o  (tmr_tc)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: enter WAIT on a partial request, leave on issue/abort
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ld_part)      state_d = WAIT;
            WAIT: if (issue || err) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM decisions: what to load, issue or abort this cycle (CE-qualified)
    always_comb begin
        issue   = 1'b0;
        err     = 1'b0;
        ecode   = ERR_NONE;
        ld_full = 1'b0;
        ld_part = 1'b0;
        ld_miss = 1'b0;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        cmd_chg = 1'b0;
`ifdef ALU_CMD_LOCK_CHECK_EN
        cmd_chg = (bus.MODE != mode_q) || (bus.CMD != cmd_q);
`endif
        if (bus.CE) begin
            case (state_q)
                IDLE: begin
                    if (req == 2'b00 || bus.INP_VALID == 2'b00) begin
                        err   = 1'b1;
                        ecode = ERR_BADREQ;
                    end else if ((bus.INP_VALID & req) == req) begin
                        issue   = 1'b1;
                        ld_full = 1'b1;
                    end else if (req == 2'b11) begin
                        ld_part = 1'b1;
                        tmr_clr = 1'b1;
                    end else begin
                        // single-operand command without its operand
                        err   = 1'b1;
                        ecode = ERR_BADREQ;
                    end
                end
                WAIT: begin
                    if (cmd_chg) begin
                        err   = 1'b1;
                        ecode = ERR_CMDCHG;
                    end else if (|(bus.INP_VALID & ~held_q)) begin
                        issue   = 1'b1;
                        ld_miss = 1'b1;
                    end else if (tmr_tc) begin
                        err   = 1'b1;
                        ecode = ERR_TIMEOUT;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operation fields and output pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q  <= 2'b00;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
            cin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ecode_q <= ERR_NONE;
        end else begin
            valid_q <= issue;
            err_q   <= err;
            ecode_q <= err ? ecode : ERR_NONE;
            if (ld_full || ld_part) begin
                mode_q <= bus.MODE;
                cmd_q  <= bus.CMD;
                cin_q  <= bus.CIN;
            end
            if (ld_full) begin
                // operands outside the requirement mask are dropped
                a_q <= req[0] ? bus.OPA : '0;
                b_q <= req[1] ? bus.OPB : '0;
            end
            if (ld_part) begin
                a_q    <= bus.INP_VALID[0] ? bus.OPA : '0;
                b_q    <= bus.INP_VALID[1] ? bus.OPB : '0;
                held_q <= bus.INP_VALID;
            end
            if (ld_miss) begin
                // only the missing operand is taken; the held one keeps its first value
                if (!held_q[0]) a_q <= bus.OPA;
                if (!held_q[1]) b_q <= bus.OPB;
                held_q <= 2'b00;
            end
        end
    end

    assign bus.op_valid = valid_q;
    assign bus.op_err   = err_q;
    assign bus.err_code = ecode_q;
    assign bus.op_mode  = mode_q;
    assign bus.op_cmd   = cmd_q;
    assign bus.op_cin   = cin_q;
    assign bus.op_a     = a_q;
    assign bus.op_b     = b_q;
    assign bus.busy     = (state_q == WAIT);
endmodule

// File: tb/tb_alu_op_collector.sv
// tb_alu_op_collector: directed vectors with hand-computed expectations.
// Honors ALU_CMD_LOCK_CHECK_EN for the command-change case.
module tb_alu_op_collector;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    alu_op_collector_if #(.DATA_WIDTH(8), .CMD_WIDTH(4)) bus ();

    alu_op_collector #(.DATA_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge; outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic mode, input logic [3:0] cmd,
                         input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
        bus.CE = ce; bus.MODE = mode; bus.CMD = cmd; bus.INP_VALID = iv;
        bus.OPA = a; bus.OPB = b; bus.CIN = cin;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        idle();
        #12;
        // reset state
        chk("rst_valid", 32'(bus.op_valid), 0);
        chk("rst_err",   32'(bus.op_err), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_ecode", 32'(bus.err_code), 0);
        chk("rst_a",     32'(bus.op_a), 0);
        chk("rst_cmd",   32'(bus.op_cmd), 0);
        @(posedge clk); #1 reset = 1'b0;

        // full two-operand request, latency 1
        drive(1, 1, 4'd0, 2'b11, 8'h12, 8'h34, 1);
        step();
        chk("full_valid", 32'(bus.op_valid), 1);
        chk("full_a",     32'(bus.op_a), 32'h12);
        chk("full_b",     32'(bus.op_b), 32'h34);
        chk("full_cin",   32'(bus.op_cin), 1);
        chk("full_err",   32'(bus.op_err), 0);
        chk("full_busy",  32'(bus.busy), 0);
        idle(); step();
        chk("full_pulse", 32'(bus.op_valid), 0);

        // split arrival with 3 empty cycles
        drive(1, 1, 4'd0, 2'b01, 8'h05, 8'h00, 0);
        step();
        chk("split_busy",  32'(bus.busy), 1);
        chk("split_noval", 32'(bus.op_valid), 0);
        drive(1, 1, 4'd0, 2'b00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 3; i++) step();
        chk("split_busy3", 32'(bus.busy), 1);
        drive(1, 1, 4'd0, 2'b10, 8'h00, 8'h07, 0);
        step();
        chk("split_valid", 32'(bus.op_valid), 1);
        chk("split_a",     32'(bus.op_a), 5);
        chk("split_b",     32'(bus.op_b), 7);
        chk("split_busy0", 32'(bus.busy), 0);
        idle(); step();

        // timeout after 16 WAIT cycles
        drive(1, 0, 4'd0, 2'b10, 8'h00, 8'h22, 0);
        step();
        drive(1, 0, 4'd0, 2'b00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_early_err", 32'(bus.op_err), 0);
        end
        chk("to_still_busy", 32'(bus.busy), 1);
        step();
        chk("to_err",   32'(bus.op_err), 1);
        chk("to_code",  32'(bus.err_code), 1);
        chk("to_valid", 32'(bus.op_valid), 0);
        chk("to_busy",  32'(bus.busy), 0);
        idle(); step();
        chk("to_once",  32'(bus.op_err), 0);

        // arrival on the final window cycle wins
        drive(1, 0, 4'd0, 2'b10, 8'h00, 8'h22, 0);
        step();
        drive(1, 0, 4'd0, 2'b00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 15; i++) step();
        drive(1, 0, 4'd0, 2'b01, 8'h44, 8'h00, 0);
        step();
        chk("last_valid", 32'(bus.op_valid), 1);
        chk("last_err",   32'(bus.op_err), 0);
        chk("last_a",     32'(bus.op_a), 32'h44);
        chk("last_b",     32'(bus.op_b), 32'h22);
        idle(); step();

        // single-operand command drops the extra operand
        drive(1, 1, 4'd4, 2'b11, 8'h09, 8'h03, 0);
        step();
        chk("single_valid", 32'(bus.op_valid), 1);
        chk("single_a",     32'(bus.op_a), 9);
        chk("single_b",     32'(bus.op_b), 0);
        // illegal command
        drive(1, 1, 4'd15, 2'b11, 8'h01, 8'h01, 0);
        step();
        chk("bad_err",   32'(bus.op_err), 1);
        chk("bad_code",  32'(bus.err_code), 2);
        chk("bad_valid", 32'(bus.op_valid), 0);
        // legal command but nothing valid
        drive(1, 0, 4'd2, 2'b00, 8'h01, 8'h01, 0);
        step();
        chk("nov_err",  32'(bus.op_err), 1);
        chk("nov_code", 32'(bus.err_code), 2);
        // logical NOT_B with only OPB
        drive(1, 0, 4'd7, 2'b10, 8'hFF, 8'h5A, 0);
        step();
        chk("notb_valid", 32'(bus.op_valid), 1);
        chk("notb_a",     32'(bus.op_a), 0);
        chk("notb_b",     32'(bus.op_b), 32'h5A);
        idle(); step();

        // CE=0 freezes WAIT; latched CIN used
        drive(1, 1, 4'd1, 2'b01, 8'h11, 8'h00, 1);
        step();
        idle();
        for (int i = 0; i < 20; i++) step();
        chk("ce_busy", 32'(bus.busy), 1);
        chk("ce_err",  32'(bus.op_err), 0);
        drive(1, 1, 4'd1, 2'b10, 8'h00, 8'h66, 0);
        step();
        chk("ce_valid", 32'(bus.op_valid), 1);
        chk("ce_a",     32'(bus.op_a), 32'h11);
        chk("ce_b",     32'(bus.op_b), 32'h66);
        chk("ce_cin",   32'(bus.op_cin), 1);
        chk("ce_cmd",   32'(bus.op_cmd), 1);
        // back-to-back request the cycle after issue
        drive(1, 0, 4'd2, 2'b11, 8'h01, 8'h02, 0);
        step();
        chk("b2b_valid", 32'(bus.op_valid), 1);
        chk("b2b_mode",  32'(bus.op_mode), 0);
        chk("b2b_cmd",   32'(bus.op_cmd), 2);
        chk("b2b_a",     32'(bus.op_a), 1);
        chk("b2b_b",     32'(bus.op_b), 2);

        // re-supplied held operand keeps first value
        drive(1, 1, 4'd0, 2'b01, 8'hAA, 8'h00, 0);
        step();
        drive(1, 1, 4'd0, 2'b01, 8'hBB, 8'h00, 0);
        step();
        chk("resup_busy",  32'(bus.busy), 1);
        chk("resup_noval", 32'(bus.op_valid), 0);
        drive(1, 1, 4'd0, 2'b11, 8'hCC, 8'hDD, 0);
        step();
        chk("resup_valid", 32'(bus.op_valid), 1);
        chk("resup_a",     32'(bus.op_a), 32'hAA);
        chk("resup_b",     32'(bus.op_b), 32'hDD);
        idle(); step();

        // reset in WAIT
        drive(1, 1, 4'd0, 2'b01, 8'h77, 8'h00, 0);
        step();
        chk("rw_busy1", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk("rw_busy0", 32'(bus.busy), 0);
        idle();
        step();
        chk("rw_valid", 32'(bus.op_valid), 0);
        chk("rw_err",   32'(bus.op_err), 0);
        reset = 1'b0;
        step();
        chk("rw_post_busy", 32'(bus.busy), 0);
        chk("rw_post_err",  32'(bus.op_err), 0);

        // command change while waiting
        drive(1, 1, 4'd0, 2'b01, 8'h03, 8'h00, 0);
        step();
        drive(1, 1, 4'd1, 2'b10, 8'h00, 8'h04, 0);
        step();
`ifdef ALU_CMD_LOCK_CHECK_EN
        chk("chg_err",   32'(bus.op_err), 1);
        chk("chg_code",  32'(bus.err_code), 3);
        chk("chg_valid", 32'(bus.op_valid), 0);
`else
        chk("chg_valid", 32'(bus.op_valid), 1);
        chk("chg_err",   32'(bus.op_err), 0);
        chk("chg_cmd",   32'(bus.op_cmd), 0);
        chk("chg_a",     32'(bus.op_a), 3);
        chk("chg_b",     32'(bus.op_b), 4);
`endif
        chk("chg_busy",  32'(bus.busy), 0);
        idle(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
